// File: rtl/apb_bridge_if.sv
// Core data-bus request/response and APB3 initiator signals of apb_bridge.
// The bridge takes the slave modport; the core/peripheral side takes master.
interface apb_bridge_if #(
    parameter int NUM_SLAVES = 4
);
    logic [31:0]              bus_addr;
    logic [31:0]              bus_wdata;
    logic                     bus_write;
    logic                     bus_valid;
    logic [31:0]              bus_rdata;
    logic                     bus_ready;
    logic                     bus_err;
    logic [31:0]              paddr;
    logic [31:0]              pwdata;
    logic                     pwrite;
    logic [NUM_SLAVES-1:0]    psel;
    logic                     penable;
    logic [NUM_SLAVES*32-1:0] prdata;
    logic [NUM_SLAVES-1:0]    pready;
    logic [NUM_SLAVES-1:0]    pslverr;

    modport slave (
        input  bus_addr, bus_wdata, bus_write, bus_valid, prdata, pready, pslverr,
        output bus_rdata, bus_ready, bus_err, paddr, pwdata, pwrite, psel, penable
    );

    modport master (
        output bus_addr, bus_wdata, bus_write, bus_valid, prdata, pready, pslverr,
        input  bus_rdata, bus_ready, bus_err, paddr, pwdata, pwrite, psel, penable
    );
endinterface

// File: rtl/apb_bridge.sv
// Core data-bus responder driving an APB3 initiator, one transfer at a time.
// Optional ACCESS-phase timeout is built in when APB_TIMEOUT_EN is defined.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for bus_valid; decodes the slave index
// S_SETUP  | psel asserted, penable low
// S_ACCESS | psel and penable asserted, waiting for pready of chosen slave
// S_DONE   | bus_ready/bus_err pulse for one cycle, bus_valid ignored
module apb_bridge #(
    parameter int NUM_SLAVES     = 4,
    parameter int SEL_LSB        = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    apb_bridge_if.slave  bus
);
    localparam int IDXW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int TW   = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    generate
        if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT_CYCLES < 1 || SEL_LSB + IDXW > 31) begin : g_cfg_err
            $error("apb_bridge: unsupported parameter set");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                r_state;
    logic [IDXW-1:0]       r_idx;
    logic [31:0]           r_paddr;
    logic [31:0]           r_pwdata;
    logic                  r_pwrite;
    logic [NUM_SLAVES-1:0] r_psel;
    logic                  r_penable;
    logic [31:0]           r_rdata;
    logic                  r_ready;
    logic                  r_err;
`ifdef APB_TIMEOUT_EN
    logic [TW-1:0]         r_tmo_cnt;
`endif

    logic [IDXW-1:0]       w_idx;
    logic                  w_dec_err;
    logic [NUM_SLAVES-1:0] w_sel_oh;
    logic                  w_sel_ready;
    logic                  w_sel_err;
    logic [31:0]           w_sel_rdata;

    // Address bits between the index field and bit 31 must be zero.
    always_comb begin
        w_idx     = bus.bus_addr[SEL_LSB +: IDXW];
        w_dec_err = (32'(w_idx) >= NUM_SLAVES) ||
                    ((bus.bus_addr[30:0] >> (SEL_LSB + IDXW)) != 31'd0);
        w_sel_oh  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_sel_oh[i] = (w_idx == IDXW'(i));
        end
    end

    // Response mux uses the latched index, so unselected slaves never leak in.
    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_err   = 1'b0;
        w_sel_rdata = 32'd0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_sel_ready = bus.pready[i];
                w_sel_err   = bus.pslverr[i];
                w_sel_rdata = bus.prdata[i*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_paddr   <= 32'd0;
            r_pwdata  <= 32'd0;
            r_pwrite  <= 1'b0;
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_rdata   <= 32'd0;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
`ifdef APB_TIMEOUT_EN
            r_tmo_cnt <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.bus_valid) begin
                        if (w_dec_err) begin
                            r_ready <= 1'b1;
                            r_err   <= 1'b1;
                            r_rdata <= 32'd0;
                            r_state <= S_DONE;
                        end else begin
                            r_paddr  <= bus.bus_addr;
                            r_pwdata <= bus.bus_wdata;
                            r_pwrite <= bus.bus_write;
                            r_idx    <= w_idx;
                            r_psel   <= w_sel_oh;
                            r_state  <= S_SETUP;
                        end
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
`ifdef APB_TIMEOUT_EN
                    r_tmo_cnt <= TW'(TIMEOUT_CYCLES - 1);
`endif
                    r_state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (w_sel_ready) begin
                        r_psel    <= '0;
                        r_penable <= 1'b0;
                        r_ready   <= 1'b1;
                        r_err     <= w_sel_err;
                        if (!r_pwrite) begin
                            r_rdata <= w_sel_err ? 32'd0 : w_sel_rdata;
                        end
                        r_state   <= S_DONE;
                    end
`ifdef APB_TIMEOUT_EN
                    // Down-counter hits zero on the TIMEOUT_CYCLES-th unready cycle.
                    else if (r_tmo_cnt == '0) begin
                        r_psel    <= '0;
                        r_penable <= 1'b0;
                        r_ready   <= 1'b1;
                        r_err     <= 1'b1;
                        if (!r_pwrite) begin
                            r_rdata <= 32'hDEAD_BEEF;
                        end
                        r_state   <= S_DONE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt - 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    r_ready <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.paddr     = r_paddr;
    assign bus.pwdata    = r_pwdata;
    assign bus.pwrite    = r_pwrite;
    assign bus.psel      = r_psel;
    assign bus.penable   = r_penable;
    assign bus.bus_rdata = r_rdata;
    assign bus.bus_ready = r_ready;
    assign bus.bus_err   = r_err;
endmodule
